// File: rtl/decode_stage_piped.sv
// -----------------------------------------------------------------------------
// decode_stage_piped
//   Pipelined instruction decode stage. It sits between fetch and execute.
//   Each instruction is decoded and its operands are picked from the GPR reads
//   or from one of NUM_FWD forwarding sources. The next PC is computed, and a
//   redirect is raised one cycle later when the flow is not sequential. The
//   result is held in an ID/EX register with a valid/ready handshake. The stage
//   stalls on a load-use hazard, supports a synchronous flush, and can squash
//   the instruction that follows a taken redirect.
//
//   Optional feature macro: DECODE_STAGE_STATS_EN
//     Defined   -> adds the saturating counters stat_stall, stat_bubble and
//                  stat_redirect.
//     Undefined -> those ports and counters are absent.
//
//   This file also holds the two helper blocks used by the stage:
//     i_decoder    : instr[31:0] -> packed 39-bit decode word
//     next_pc_calc : pc/instr/operands -> next_pc
//
// Ports (decode_stage_piped):
//   clk, rst                     clock, async active-high reset
//   flush                        sync kill of ID/EX and squash state
//   in_valid/in_ready            fetch handshake
//   in_instr, in_pc              fetched instruction and its PC
//   a_gpr, b_gpr                 register file reads for rs/rt
//   fwd_data                     NUM_FWD forwarding values, slice k-1 = source k
//   fwd_sel_a, fwd_sel_b         0 = GPR, k = source k, out of range = GPR
//   ex_load_valid, ex_load_rd    load currently in execute
//   rs, rt                       combinational source fields for hazard unit
//   redirect_valid, redirect_pc  registered one-cycle redirect
//   out_valid/out_ready          ID/EX handshake
//   out_pc, out_a, out_b         registered PC and operands
//   out_rs, out_rt, out_dec      registered source fields and decode word
// -----------------------------------------------------------------------------

// Decode word layout, MSB first:
//   [38:35] alu_op  [34] reg_write  [33] mem_read  [32] mem_write
//   [31] is_branch  [30] is_jump    [29] jump_reg  [28] use_imm
//   [27] sign_ext   [26] link       [25:0] raw instr[25:0]
module i_decoder (
  input  logic [31:0] instr,
  output logic [38:0] dec
);
  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  logic [3:0] alu_op_s;
  logic       reg_write_s, mem_read_s, mem_write_s, is_branch_s;
  logic       is_jump_s, jump_reg_s, use_imm_s, sign_ext_s, link_s;

  assign opcode_s = instr[31:26];
  assign funct_s  = instr[5:0];

  // Control decode from opcode and funct.
  always_comb begin
    alu_op_s    = 4'd0;
    reg_write_s = 1'b0;
    mem_read_s  = 1'b0;
    mem_write_s = 1'b0;
    is_branch_s = 1'b0;
    is_jump_s   = 1'b0;
    jump_reg_s  = 1'b0;
    use_imm_s   = 1'b0;
    sign_ext_s  = 1'b0;
    link_s      = 1'b0;
    case (opcode_s)
      6'h00: begin
        case (funct_s)
          6'h20, 6'h21: begin alu_op_s = 4'd0; reg_write_s = 1'b1; end
          6'h22, 6'h23: begin alu_op_s = 4'd1; reg_write_s = 1'b1; end
          6'h24:        begin alu_op_s = 4'd2; reg_write_s = 1'b1; end
          6'h25:        begin alu_op_s = 4'd3; reg_write_s = 1'b1; end
          6'h2A:        begin alu_op_s = 4'd4; reg_write_s = 1'b1; end
          6'h08:        begin is_jump_s = 1'b1; jump_reg_s = 1'b1; end
          6'h09: begin
            is_jump_s   = 1'b1;
            jump_reg_s  = 1'b1;
            link_s      = 1'b1;
            reg_write_s = 1'b1;
          end
          default: begin end
        endcase
      end
      6'h02: is_jump_s = 1'b1;
      6'h03: begin is_jump_s = 1'b1; link_s = 1'b1; reg_write_s = 1'b1; end
      6'h04, 6'h05: begin is_branch_s = 1'b1; alu_op_s = 4'd1; sign_ext_s = 1'b1; end
      6'h08, 6'h09: begin use_imm_s = 1'b1; sign_ext_s = 1'b1; reg_write_s = 1'b1; end
      6'h0C: begin alu_op_s = 4'd2; use_imm_s = 1'b1; reg_write_s = 1'b1; end
      6'h0D: begin alu_op_s = 4'd3; use_imm_s = 1'b1; reg_write_s = 1'b1; end
      6'h0F: begin alu_op_s = 4'd5; use_imm_s = 1'b1; reg_write_s = 1'b1; end
      6'h23: begin
        use_imm_s   = 1'b1;
        sign_ext_s  = 1'b1;
        reg_write_s = 1'b1;
        mem_read_s  = 1'b1;
      end
      6'h2B: begin use_imm_s = 1'b1; sign_ext_s = 1'b1; mem_write_s = 1'b1; end
      default: begin end
    endcase
  end

  assign dec = {alu_op_s, reg_write_s, mem_read_s, mem_write_s, is_branch_s,
                is_jump_s, jump_reg_s, use_imm_s, sign_ext_s, link_s, instr[25:0]};
endmodule

// Next PC: BEQ/BNE relative, J/JAL region jump, JR/JALR through operand a.
module next_pc_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] next_pc
);
  logic [XLEN-1:0] seq_pc_s;
  logic [XLEN-1:0] br_off_s;

  assign seq_pc_s = pc + XLEN'(32'd4);
  assign br_off_s = {{(XLEN-18){instr[15]}}, instr[15:0], 2'b00};

  // Target selection by opcode.
  always_comb begin
    next_pc = seq_pc_s;
    case (instr[31:26])
      6'h02, 6'h03: next_pc = {seq_pc_s[XLEN-1:28], instr[25:0], 2'b00};
      6'h04: begin
        if (a == b) next_pc = seq_pc_s + br_off_s;
        else        next_pc = seq_pc_s;
      end
      6'h05: begin
        if (a != b) next_pc = seq_pc_s + br_off_s;
        else        next_pc = seq_pc_s;
      end
      6'h00: begin
        if (instr[5:0] == 6'h08 || instr[5:0] == 6'h09) next_pc = a;
        else                                            next_pc = seq_pc_s;
      end
      default: next_pc = seq_pc_s;
    endcase
  end
endmodule

module decode_stage_piped #(
  parameter int XLEN       = 32,
  parameter int NUM_FWD    = 3,
  parameter int DEC_W      = 39,
  parameter int DELAY_SLOT = 1,
  localparam int FSEL_W    = $clog2(NUM_FWD + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         a_gpr,
  input  logic [XLEN-1:0]         b_gpr,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic [FSEL_W-1:0]       fwd_sel_a,
  input  logic [FSEL_W-1:0]       fwd_sel_b,
  input  logic                    ex_load_valid,
  input  logic [4:0]              ex_load_rd,
  output logic [4:0]              rs,
  output logic [4:0]              rt,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_a,
  output logic [XLEN-1:0]         out_b,
  output logic [4:0]              out_rs,
  output logic [4:0]              out_rt,
  output logic [DEC_W-1:0]        out_dec
`ifdef DECODE_STAGE_STATS_EN
  ,
  output logic [15:0]             stat_stall,
  output logic [15:0]             stat_bubble,
  output logic [15:0]             stat_redirect
`endif
);
  typedef enum logic [0:0] {RUN = 1'b0, SQUASH = 1'b1} state_t;

  state_t          state_r, state_nxt_s;
  logic            hazard_s, load_en_s, fire_s, take_redirect_s;
  logic [XLEN-1:0] op_a_s, op_b_s, next_pc_s, seq_pc_s;
  logic [DEC_W-1:0] dec_s;

  // Out-of-range selects keep the GPR value.
  function automatic logic [XLEN-1:0] fwd_pick(
    input logic [FSEL_W-1:0]       sel,
    input logic [XLEN-1:0]         gpr,
    input logic [NUM_FWD*XLEN-1:0] fwd
  );
    logic [XLEN-1:0] v;
    v = gpr;
    for (int k = 1; k <= NUM_FWD; k++) begin
      v = (sel == FSEL_W'(k)) ? fwd[(k-1)*XLEN +: XLEN] : v;
    end
    return v;
  endfunction

  assign rs     = in_instr[25:21];
  assign rt     = in_instr[20:16];
  assign op_a_s = fwd_pick(fwd_sel_a, a_gpr, fwd_data);
  assign op_b_s = fwd_pick(fwd_sel_b, b_gpr, fwd_data);

  // r0 never creates a dependency, so a load into it never stalls.
  assign hazard_s  = ex_load_valid && (ex_load_rd != 5'd0) &&
                     ((ex_load_rd == rs) || (ex_load_rd == rt));
  assign load_en_s = !out_valid || out_ready;
  assign in_ready  = load_en_s && !hazard_s && !flush;
  assign fire_s    = in_valid && in_ready;

  assign seq_pc_s        = in_pc + XLEN'(32'd4);
  assign take_redirect_s = fire_s && (state_r == RUN) && (next_pc_s != seq_pc_s);

  i_decoder u_dec (
    .instr (in_instr),
    .dec   (dec_s)
  );

  next_pc_calc #(.XLEN(XLEN)) u_npc (
    .pc      (in_pc),
    .instr   (in_instr),
    .a       (op_a_s),
    .b       (op_b_s),
    .next_pc (next_pc_s)
  );

  // Squash state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= RUN;
    else     state_r <= state_nxt_s;
  end

  // Squash next state: armed by a redirect without a delay slot, cleared by the
  // next consumed instruction or a flush.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = RUN;
    end else if (fire_s) begin
      if (state_r == SQUASH)                           state_nxt_s = RUN;
      else if (take_redirect_s && (DELAY_SLOT == 0))   state_nxt_s = SQUASH;
      else                                             state_nxt_s = RUN;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // ID/EX register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_rs    <= 5'd0;
      out_rt    <= 5'd0;
      out_dec   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (fire_s && (state_r == SQUASH)) begin
      out_valid <= 1'b0;
    end else if (fire_s) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      out_a     <= op_a_s;
      out_b     <= op_b_s;
      out_rs    <= rs;
      out_rt    <= rt;
      out_dec   <= dec_s;
    end else if (load_en_s) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // Redirect pulse; the target is held between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (flush) begin
      redirect_valid <= 1'b0;
    end else if (take_redirect_s) begin
      redirect_valid <= 1'b1;
      redirect_pc    <= next_pc_s;
    end else begin
      redirect_valid <= 1'b0;
    end
  end

`ifdef DECODE_STAGE_STATS_EN
  logic bubble_s;

  assign bubble_s = !flush && !fire_s && load_en_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall    <= 16'd0;
      stat_bubble   <= 16'd0;
      stat_redirect <= 16'd0;
    end else begin
      stat_stall    <= (in_valid && hazard_s) ? sat_inc(stat_stall)    : stat_stall;
      stat_bubble   <= bubble_s               ? sat_inc(stat_bubble)   : stat_bubble;
      stat_redirect <= redirect_valid         ? sat_inc(stat_redirect) : stat_redirect;
    end
  end
`endif
endmodule

// File: tb/tb_decode_stage_piped.sv
// Bench for decode_stage_piped: u_dut has no delay slot, u_ds keeps it, and
// both see the same stimulus. A scoreboard queue holds the expected ID/EX
// contents for u_dut.
module tb_decode_stage_piped;
  localparam int XLEN    = 32;
  localparam int NUM_FWD = 3;
  localparam int DEC_W   = 39;
  localparam int FSEL_W  = $clog2(NUM_FWD + 1);

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready, ex_load_valid;
  logic [31:0] in_instr;
  logic [XLEN-1:0] in_pc, a_gpr, b_gpr;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic [FSEL_W-1:0] fwd_sel_a, fwd_sel_b;
  logic [4:0] ex_load_rd;

  logic in_ready, redirect_valid, out_valid;
  logic [4:0] rs, rt, out_rs, out_rt;
  logic [XLEN-1:0] redirect_pc, out_pc, out_a, out_b;
  logic [DEC_W-1:0] out_dec;

  logic in_ready1, redirect_valid1, out_valid1;
  logic [4:0] rs1, rt1, out_rs1, out_rt1;
  logic [XLEN-1:0] redirect_pc1, out_pc1, out_a1, out_b1;
  logic [DEC_W-1:0] out_dec1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [25:0] low;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_stage_piped #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .DEC_W(DEC_W), .DELAY_SLOT(0)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .a_gpr(a_gpr), .b_gpr(b_gpr),
    .fwd_data(fwd_data), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .rs(rs), .rt(rt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_a(out_a),
    .out_b(out_b), .out_rs(out_rs), .out_rt(out_rt), .out_dec(out_dec)
  );

  decode_stage_piped #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .DEC_W(DEC_W), .DELAY_SLOT(1)) u_ds (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .in_pc(in_pc), .a_gpr(a_gpr), .b_gpr(b_gpr),
    .fwd_data(fwd_data), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .rs(rs1), .rt(rt1),
    .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_pc(out_pc1), .out_a(out_a1),
    .out_b(out_b1), .out_rs(out_rs1), .out_rt(out_rt1), .out_dec(out_dec1)
  );

  function automatic logic [31:0] mk_add(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] mk_beq(input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
    return {6'h04, s, t, imm};
  endfunction

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic push_exp(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.pc  = pc;
    e.a   = a;
    e.b   = b;
    e.rs  = instr[25:21];
    e.rt  = instr[20:16];
    e.low = instr[25:0];
    sb.push_back(e);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every ID/EX transfer must match the oldest entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: got pc=%h, required no transfer", out_pc);
      end else begin
        e = sb.pop_front();
        if ({out_pc, out_a, out_b, out_rs, out_rt, out_dec[25:0]} !== e) begin
          fails++;
          $display("FAIL sb_idex: got %h required %h",
                   {out_pc, out_a, out_b, out_rs, out_rt, out_dec[25:0]}, e);
        end
      end
    end
  end

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if ({redirect_valid, redirect_pc, out_valid, out_pc, out_a, out_b, out_rs, out_rt, out_dec} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0",
               {redirect_valid, redirect_pc, out_valid, out_pc, out_a, out_b, out_rs, out_rt, out_dec});
    end
    tests++;
    if ({redirect_valid1, redirect_pc1, out_valid1, out_pc1, out_a1, out_b1, out_rs1, out_rt1, out_dec1, rs1, rt1} !== '0) begin
      fails++;
      $display("FAIL reset_outputs_ds: got %h required 0",
               {redirect_valid1, redirect_pc1, out_valid1, out_pc1, out_a1, out_b1, out_rs1, out_rt1, out_dec1, rs1, rt1});
    end
    tests++;
    if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b/%b required 1/1", in_ready, in_ready1);
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_stream;
    logic [31:0] instr;
    out_ready = 1'b1;
    a_gpr = 32'h1000;
    b_gpr = 32'h2000;
    instr = mk_add(5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        drive(instr, 32'h100 + 32'(4 * i));
        push_exp(instr, 32'h100 + 32'(4 * i), 32'h1000, 32'h2000);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      tests++;
      if (out_valid !== ((i >= 1) && (i <= 3))) begin
        fails++;
        $display("FAIL stream_valid[%0d]: got %b required %b", i, out_valid, ((i >= 1) && (i <= 3)));
      end
      tests++;
      if (redirect_valid !== 1'b0) begin
        fails++;
        $display("FAIL stream_redirect[%0d]: got %b required 0", i, redirect_valid);
      end
      next_cycle();
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL stream_drain: got %0d left required 0", sb.size());
    end
  endtask

  task automatic test_forwarding;
    logic [31:0] exp_a [0:4];
    logic [31:0] instr, eb;
    logic [2:0]  sel_v;
    exp_a[0] = 32'h11; exp_a[1] = 32'hA1; exp_a[2] = 32'hB2; exp_a[3] = 32'hC3; exp_a[4] = 32'h11;
    out_ready = 1'b1;
    a_gpr = 32'h11;
    b_gpr = 32'h22;
    fwd_data = {32'hC3, 32'hB2, 32'hA1};
    instr = mk_add(5'd4, 5'd5, 5'd6);
    for (int s = 0; s < 5; s++) begin
      sel_v = 3'(s);
      fwd_sel_a = sel_v[FSEL_W-1:0];
      fwd_sel_b = (s == 2) ? 2'd1 : 2'd0;
      eb = (s == 2) ? 32'hA1 : 32'h22;
      drive(instr, 32'h180 + 32'(4 * s));
      push_exp(instr, 32'h180 + 32'(4 * s), exp_a[s], eb);
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL fwd_in_ready[%0d]: got %b required 1", s, in_ready);
      end
      next_cycle();
    end
    in_valid = 1'b0;
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    next_cycle();
    next_cycle();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL fwd_drain: got %0d left required 0", sb.size());
    end
  endtask

  task automatic test_load_use;
    logic [31:0] ix, iy, iz;
    ix = mk_add(5'd1, 5'd2, 5'd3);
    iy = mk_add(5'd8, 5'd2, 5'd9);
    iz = mk_add(5'd0, 5'd0, 5'd10);
    out_ready = 1'b1;
    a_gpr = 32'h33;
    b_gpr = 32'h44;
    ex_load_valid = 1'b0;
    drive(ix, 32'h2FC);
    push_exp(ix, 32'h2FC, 32'h33, 32'h44);
    next_cycle();
    ex_load_valid = 1'b1;
    ex_load_rd = 5'd8;
    drive(iy, 32'h300);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || rs !== 5'd8 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL lu_stall: got ready=%b rs=%0d valid=%b required 0/8/1", in_ready, rs, out_valid);
    end
    next_cycle();
    ex_load_valid = 1'b0;
    push_exp(iy, 32'h300, 32'h33, 32'h44);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL lu_bubble: got valid=%b ready=%b required 0/1", out_valid, in_ready);
    end
    next_cycle();
    ex_load_valid = 1'b1;
    ex_load_rd = 5'd0;
    drive(iz, 32'h304);
    push_exp(iz, 32'h304, 32'h33, 32'h44);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL lu_rd0: got ready=%b valid=%b required 1/1", in_ready, out_valid);
    end
    next_cycle();
    ex_load_valid = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL lu_issue_rd0: got %b required 1", out_valid);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      fails++;
      $display("FAIL lu_drain: got valid=%b left=%0d required 0/0", out_valid, sb.size());
    end
    next_cycle();
  endtask

  task automatic test_backpressure;
    logic [31:0] i1, i2;
    i1 = mk_add(5'd1, 5'd2, 5'd3);
    i2 = mk_add(5'd3, 5'd4, 5'd5);
    out_ready = 1'b1;
    a_gpr = 32'h44;
    b_gpr = 32'h22;
    drive(i1, 32'h400);
    push_exp(i1, 32'h400, 32'h44, 32'h22);
    next_cycle();
    for (int j = 0; j < 3; j++) begin
      out_ready = 1'b0;
      a_gpr = 32'h55;
      ex_load_valid = (j == 1);
      ex_load_rd = 5'd3;
      drive(i2, 32'h404);
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h400 ||
          out_a !== 32'h44 || out_rs !== 5'd1) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got ready=%b valid=%b pc=%h a=%h rs=%0d required 0/1/400/44/1",
                 j, in_ready, out_valid, out_pc, out_a, out_rs);
      end
      next_cycle();
    end
    out_ready = 1'b1;
    ex_load_valid = 1'b0;
    push_exp(i2, 32'h404, 32'h55, 32'h22);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: got %b required 1", in_ready);
    end
    next_cycle();
    in_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL bp_drain: got %0d left required 0", sb.size());
    end
    next_cycle();
  endtask

  task automatic test_branch;
    logic [31:0] ib0, ib1, ia;
    ib0 = mk_beq(5'd1, 5'd2, 16'h000F);
    ib1 = mk_beq(5'd3, 5'd4, 16'h0003);
    ia  = mk_add(5'd1, 5'd2, 5'd3);
    out_ready = 1'b1;
    a_gpr = 32'h77;
    b_gpr = 32'h77;
    drive(ib0, 32'h200);
    push_exp(ib0, 32'h200, 32'h77, 32'h77);
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || redirect_valid !== 1'b0) begin
      fails++;
      $display("FAIL br_accept: got ready=%b redir=%b required 1/0", in_ready, redirect_valid);
    end
    next_cycle();
    drive(ib1, 32'h204);
    @(negedge clk);
    tests++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h240 ||
        redirect_valid1 !== 1'b1 || redirect_pc1 !== 32'h240) begin
      fails++;
      $display("FAIL br_redirect: got %b/%h ds %b/%h required 1/240 both",
               redirect_valid, redirect_pc, redirect_valid1, redirect_pc1);
    end
    next_cycle();
    drive(ia, 32'h240);
    push_exp(ia, 32'h240, 32'h77, 32'h77);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      fails++;
      $display("FAIL br_squash: got valid=%b redir=%b required 0/0", out_valid, redirect_valid);
    end
    tests++;
    if (out_valid1 !== 1'b1 || out_pc1 !== 32'h204 ||
        redirect_valid1 !== 1'b1 || redirect_pc1 !== 32'h214) begin
      fails++;
      $display("FAIL br_delay_slot: got %b/%h redir %b/%h required 1/204 1/214",
               out_valid1, out_pc1, redirect_valid1, redirect_pc1);
    end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_valid1 !== 1'b1 || out_pc1 !== 32'h240 || redirect_valid !== 1'b0) begin
      fails++;
      $display("FAIL br_target: got %b ds %b/%h redir %b required 1 1/240 0",
               out_valid, out_valid1, out_pc1, redirect_valid);
    end
    next_cycle();
    @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL br_drain: got %0d left required 0", sb.size());
    end
    next_cycle();
  endtask

  task automatic test_flush_reset;
    logic [31:0] ib, i1, i2;
    ib = mk_beq(5'd1, 5'd2, 16'hFFFF);
    i1 = mk_add(5'd1, 5'd2, 5'd3);
    i2 = mk_add(5'd5, 5'd6, 5'd7);
    out_ready = 1'b1;
    a_gpr = 32'h77;
    b_gpr = 32'h77;
    drive(ib, 32'h500);
    push_exp(ib, 32'h500, 32'h77, 32'h77);
    next_cycle();
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h500) begin
      fails++;
      $display("FAIL fl_flush_cycle: got ready=%b redir=%b/%h required 0/1/500",
               in_ready, redirect_valid, redirect_pc);
    end
    next_cycle();
    flush = 1'b0;
    drive(i1, 32'h504);
    push_exp(i1, 32'h504, 32'h77, 32'h77);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || redirect_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL fl_after: got valid=%b redir=%b ready=%b required 0/0/1",
               out_valid, redirect_valid, in_ready);
    end
    next_cycle();
    drive(i2, 32'h600);
    push_exp(i2, 32'h600, 32'h77, 32'h77);
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL fl_issue: got %b required 1", out_valid);
    end
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, out_pc, out_a, redirect_valid, redirect_pc, out_dec, out_valid1, out_pc1} !== '0) begin
      fails++;
      $display("FAIL rst_async: got %h required 0",
               {out_valid, out_pc, out_a, redirect_valid, redirect_pc, out_dec, out_valid1, out_pc1});
    end
    #1;
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      fails++;
      $display("FAIL rst_after: got valid=%b left=%0d required 0/0", out_valid, sb.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    ex_load_valid = 1'b0;
    ex_load_rd = 5'd0;
    in_instr = 32'd0;
    in_pc = 32'd0;
    a_gpr = 32'd0;
    b_gpr = 32'd0;
    fwd_data = '0;
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    test_reset();
    test_stream();
    test_forwarding();
    test_load_use();
    test_backpressure();
    test_branch();
    test_flush_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decode_stage_piped.md
Name: decode_stage_piped

Overview:
- Parametrised successor to the combinational decode stage.
- Decodes the fetched instruction and selects operands from the GPR value or one of NUM_FWD forwarding sources.
- Computes next PC and issues a registered redirect.
- Holds the result in an ID/EX register with valid/ready handshake, load-use hazard stall, flush, and optional squash of the post-branch instruction.
- Sits between fetch and execute; instantiates the existing i_decoder and next_pc_calc.

Parameters:
- XLEN, 32, data/PC width.
- NUM_FWD, 3, number of forwarding sources; index 1 is the youngest stage (execute).
- DEC_W, 39, packed decoder word width; must match i_decoder.
- DELAY_SLOT, 1, 1 = MIPS delay slot kept; 0 = first instruction accepted after a taken redirect is squashed.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of ID/EX contents and squash state
- in_valid  in  1  fetch presents instr/pc
- in_ready  out  1  stage accepts this cycle
- in_instr  in  32  fetched instruction
- in_pc  in  XLEN  PC of in_instr
- a_gpr, b_gpr  in  XLEN  register file reads for rs/rt
- fwd_data  in  NUM_FWD*XLEN  forwarding values; slice k-1 is source k
- fwd_sel_a, fwd_sel_b  in  FSEL_W=$clog2(NUM_FWD+1)  0 = GPR, k = source k
- ex_load_valid  in  1  a load currently occupies execute
- ex_load_rd  in  5  destination register of that load
- rs, rt  out  5  combinational source fields of in_instr, for the hazard unit
- redirect_valid  out  1  registered one-cycle pulse
- redirect_pc  out  XLEN  target PC
- out_valid  out  1  ID/EX valid
- out_ready  in  1  execute accepts
- out_pc, out_a, out_b  out  XLEN  registered pc and forwarded operands
- out_rs, out_rt  out  5  registered source fields
- out_dec  out  DEC_W  registered decoder word

Behaviour:
- Reset (async): all outputs registered low/zero; state = RUN.
- Operand select: fwd_sel = 0 selects GPR; 1..NUM_FWD selects the matching source; any out-of-range select falls back to GPR. Selection is purely combinational; next_pc_calc uses the forwarded operands.
- hazard = ex_load_valid && ex_load_rd != 0 && (ex_load_rd == rs || ex_load_rd == rt).
- load_en = !out_valid || out_ready.
- in_ready = load_en && !hazard && !flush.
- fire = in_valid && in_ready.
- ID/EX update, evaluated in priority order:
  1. flush: out_valid <= 0.
  2. fire && state == SQUASH: out_valid <= 0; state <= RUN. Instruction consumed, not issued.
  3. fire: register all out_* fields; out_valid <= 1.
  4. load_en && !fire: out_valid <= 0. Covers hazard bubbles and idle fetch.
  5. Otherwise hold all fields (backpressure).
- Latency: one cycle in_valid->out_valid; zero throughput loss when not stalled.
- Redirect: on fire in RUN with next_pc != in_pc + 4 (XLEN modulo arithmetic, wraps at 2^XLEN):
  - next cycle redirect_valid = 1 and redirect_pc = next_pc; otherwise redirect_valid = 0.
  - If DELAY_SLOT = 0, state <= SQUASH as well.
- A squashed instruction never redirects.
- SQUASH persists across stall/backpressure cycles until one instruction fires or flush.
- flush forces state <= RUN and redirect_valid <= 0 next cycle.
- A hazard during backpressure has no extra effect; the ID/EX contents are held.
- Reset mid-stall clears everything; no instruction is replayed by this block.

Optional Feature:
- Macro DECODE_STAGE_STATS_EN.
- When defined: adds outputs stat_stall [15:0], stat_bubble [15:0], stat_redirect [15:0]. These are saturating counters (stick at 16'hFFFF), reset to 0, and count respectively:
  - cycles with in_valid && hazard;
  - cycles in which case 4 inserts a bubble;
  - redirect_valid pulses.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Stream: in_pc = 0x100, 0x104, 0x108 (ADDs), out_ready = 1 -> out_pc = 0x100, 0x104, 0x108 on consecutive cycles one cycle later; redirect_valid stays 0.
- Forwarding (NUM_FWD = 3): a_gpr = 0x11, fwd_data sources 1..3 = 0xA1, 0xB2, 0xC3; fwd_sel_a = 0..3 then 4 -> out_a = 0x11, 0xA1, 0xB2, 0xC3, 0x11.
- Load-use: ex_load_valid = 1, ex_load_rd = 8, instruction rs = 8 -> in_ready = 0; one bubble (out_valid = 0); instruction issues the cycle after ex_load_valid drops. With ex_load_rd = 0 -> no stall.
- Backpressure: out_valid = 1 and out_ready = 0 for 3 cycles -> in_ready = 0; out_* stable; instruction taken on the first ready cycle.
- Branch with DELAY_SLOT = 0: BEQ at 0x200 taken to 0x240 -> redirect_valid one pulse with redirect_pc = 0x240; the instruction at 0x204 is consumed with out_valid = 0; 0x240 issues. With DELAY_SLOT = 1, 0x204 issues.
- Flush plus async reset: flush asserted in SQUASH -> out_valid = 0, next fire issues normally. rst pulsed mid-stream -> all outputs 0 immediately (asynchronous).
